// File: rtl/seq_detector_param.sv
// Parametrised Moore serial pattern detector with saturating match counter.
// Define SEQ_DET_PROG_EN to add a runtime-loadable pattern register (pat_load/pat_in).
module seq_detector_param #(
  parameter int PAT_W = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             overlap,
  input  logic             clr_count,
`ifdef SEQ_DET_PROG_EN
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
`endif
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_W - 1);

  // Only the newest PAT_W-1 bits are ever compared, so the oldest history bit is not stored.
  logic [PAT_W-2:0]  hist;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  cand;
  logic [PAT_W-1:0]  pat_cur;
  logic              load;
  logic              hit;
  logic [CNT_W-1:0]  count_next;

`ifdef SEQ_DET_PROG_EN
  logic [PAT_W-1:0] pat_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_reg <= PATTERN;
    end else if (pat_load) begin
      pat_reg <= pat_in;
    end
  end

  assign pat_cur = pat_reg;
  assign load    = pat_load;
`else
  assign pat_cur = PATTERN;
  assign load    = 1'b0;
`endif

  // A pattern load discards the bit accepted on the same edge, so it can never hit.
  always_comb begin
    cand       = {hist, x};
    hit        = en && !load && (fill >= FILL_ARM) && (cand == pat_cur);
    count_next = match_count;
    if (clr_count) begin
      count_next = '0;
    end else if (hit && !(&match_count)) begin
      count_next = match_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist        <= '0;
      fill        <= '0;
      match       <= 1'b0;
      match_count <= '0;
      count_sat   <= 1'b0;
    end else begin
      match_count <= count_next;
      count_sat   <= &count_next;
      if (load) begin
        hist  <= '0;
        fill  <= '0;
        match <= 1'b0;
      end else if (en) begin
        match <= hit;
        if (hit && !overlap) begin
          hist <= '0;
          fill <= '0;
        end else begin
          hist <= cand[PAT_W-2:0];
          if (fill != FILL_FULL) begin
            fill <= fill + FILL_W'(1);
          end
        end
      end else begin
        match <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed vector table, a saturation
// sequence on a small instance, and random traffic against a bit-queue reference model.
module tb_seq_detector_param;

  logic       clk;
  logic       reset;
  logic       en;
  logic       x;
  logic       overlap;
  logic       clr_count;
  logic       match;
  logic [7:0] match_count;
  logic       count_sat;
  logic       match2;
  logic [1:0] match_count2;
  logic       count_sat2;
`ifdef SEQ_DET_PROG_EN
  logic       pat_load;
  logic [3:0] pat_in;
  logic       pat_load2;
  logic [1:0] pat_in2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic do_rst;
    logic en;
    logic x;
    logic ov;
    logic clr;
    logic exp_match;
    int   exp_count;
  } vec_t;

  vec_t vecs[$];

  // Reference model: the accepted bits since the last reset or non-overlapping hit.
  bit         mq[$];
  int         m_count;
  bit         m_match;
  logic [3:0] model_pat;

  seq_detector_param dut (
    .clk(clk), .reset(reset), .en(en), .x(x), .overlap(overlap), .clr_count(clr_count),
`ifdef SEQ_DET_PROG_EN
    .pat_load(pat_load), .pat_in(pat_in),
`endif
    .match(match), .match_count(match_count), .count_sat(count_sat)
  );

  seq_detector_param #(.PAT_W(2), .PATTERN(2'b11), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .x(x), .overlap(overlap), .clr_count(clr_count),
`ifdef SEQ_DET_PROG_EN
    .pat_load(pat_load2), .pat_in(pat_in2),
`endif
    .match(match2), .match_count(match_count2), .count_sat(count_sat2)
  );

  always #5 clk = ~clk;

  function automatic void addVec(logic r, logic e, logic b, logic ov, logic c, logic m, int cnt);
    vec_t v;
    v.do_rst = r; v.en = e; v.x = b; v.ov = ov; v.clr = c; v.exp_match = m; v.exp_count = cnt;
    vecs.push_back(v);
  endfunction

  function automatic void modelStep(logic e, logic b, logic ov, logic c);
    bit hit;
    hit = 1'b0;
    if (e) begin
      mq.push_back(b);
      if (mq.size() >= 4) begin
        hit = 1'b1;
        for (int i = 0; i < 4; i++) begin
          if (mq[mq.size() - 4 + i] != model_pat[3 - i]) hit = 1'b0;
        end
      end
      if (hit && !ov) mq.delete();
      while (mq.size() > 4) void'(mq.pop_front());
    end
    m_match = hit;
    if (c) m_count = 0;
    else if (hit && m_count < 255) m_count++;
  endfunction

  task automatic checkOutput(string name, int actual, int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Called just after a falling edge; drives one cycle and returns at the next falling edge.
  task automatic applyStimulus(logic e, logic b, logic ov, logic c);
    en = e; x = b; overlap = ov; clr_count = c;
    @(posedge clk);
    modelStep(e, b, ov, c);
    @(negedge clk);
  endtask

  task automatic doReset();
    en = 1'b0; x = 1'b0; clr_count = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mq.delete();
    m_count = 0;
    m_match = 1'b0;
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; en = 1'b0; x = 1'b0; overlap = 1'b1; clr_count = 1'b0;
    model_pat = 4'b1010; m_count = 0; m_match = 1'b0;
`ifdef SEQ_DET_PROG_EN
    pat_load = 1'b0; pat_in = 4'b1010; pat_load2 = 1'b0; pat_in2 = 2'b11;
`endif
    #1 reset = 1'b0;
    en = 1'b1; x = 1'b1; clr_count = 1'b0;
    #15;
    checkOutput("reset match", int'(match), 0);
    checkOutput("reset count", int'(match_count), 0);
    checkOutput("reset sat", int'(count_sat), 0);
    checkOutput("reset count2", int'(match_count2), 0);
    @(negedge clk);
    reset = 1'b1;

    // overlapping 101010
    addVec(0,1,1,1,0,0,0); addVec(0,1,0,1,0,0,0); addVec(0,1,1,1,0,0,0);
    addVec(0,1,0,1,0,1,1); addVec(0,1,1,1,0,0,1); addVec(0,1,0,1,0,1,2);
    // non-overlapping 10101010
    addVec(1,1,1,0,0,0,0); addVec(0,1,0,0,0,0,0); addVec(0,1,1,0,0,0,0);
    addVec(0,1,0,0,0,1,1); addVec(0,1,1,0,0,0,1); addVec(0,1,0,0,0,0,1);
    addVec(0,1,1,0,0,0,1); addVec(0,1,0,0,0,1,2);
    // enable gap of three cycles with junk x
    addVec(1,1,1,1,0,0,0); addVec(0,1,0,1,0,0,0); addVec(0,0,1,1,0,0,0);
    addVec(0,0,1,1,0,0,0); addVec(0,0,0,1,0,0,0); addVec(0,1,1,1,0,0,0);
    addVec(0,1,0,1,0,1,1);
    // reset mid-pattern discards history
    addVec(1,1,1,1,0,0,0); addVec(0,1,0,1,0,0,0); addVec(0,1,1,1,0,0,0);
    addVec(1,1,0,1,0,0,0); addVec(0,1,1,1,0,0,0); addVec(0,1,0,1,0,0,0);
    addVec(0,1,1,1,0,0,0); addVec(0,1,0,1,0,1,1);
    // clear wins over a simultaneous hit, match still fires
    addVec(0,1,1,1,0,0,1); addVec(0,1,0,1,1,1,0); addVec(0,0,0,1,0,0,0);

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) doReset();
      applyStimulus(vecs[i].en, vecs[i].x, vecs[i].ov, vecs[i].clr);
      checkOutput($sformatf("vec%0d match", i), int'(match), int'(vecs[i].exp_match));
      checkOutput($sformatf("vec%0d count", i), int'(match_count), vecs[i].exp_count);
      checkOutput($sformatf("vec%0d sat", i), int'(count_sat), 0);
    end

    // 2-bit counter saturates on back-to-back 11 hits, then clears
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 1, 1, 0);
      checkOutput($sformatf("sat%0d match", i), int'(match2), (i >= 1) ? 1 : 0);
      checkOutput($sformatf("sat%0d count", i), int'(match_count2), (i < 3) ? i : 3);
      checkOutput($sformatf("sat%0d sat", i), int'(count_sat2), (i >= 3) ? 1 : 0);
    end
    applyStimulus(0, 0, 1, 1);
    checkOutput("clr count", int'(match_count2), 0);
    checkOutput("clr sat", int'(count_sat2), 0);
    checkOutput("clr match", int'(match2), 0);

    doReset();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) != 0), ($urandom_range(0, 49) == 0));
      checkOutput($sformatf("rnd%0d match", i), int'(match), int'(m_match));
      checkOutput($sformatf("rnd%0d count", i), int'(match_count), m_count);
      checkOutput($sformatf("rnd%0d sat", i), int'(count_sat), (m_count == 255) ? 1 : 0);
    end

`ifdef SEQ_DET_PROG_EN
    doReset();
    pat_load = 1'b1; pat_in = 4'b0110;
    applyStimulus(1, 0, 0, 0);
    pat_load = 1'b0;
    checkOutput("load match", int'(match), 0);
    applyStimulus(1, 0, 0, 0); checkOutput("prog b1", int'(match), 0);
    applyStimulus(1, 1, 0, 0); checkOutput("prog b2", int'(match), 0);
    applyStimulus(1, 1, 0, 0); checkOutput("prog b3", int'(match), 0);
    applyStimulus(1, 0, 0, 0); checkOutput("prog b4", int'(match), 1);
    applyStimulus(1, 1, 0, 0); checkOutput("old b1", int'(match), 0);
    applyStimulus(1, 0, 0, 0); checkOutput("old b2", int'(match), 0);
    applyStimulus(1, 1, 0, 0); checkOutput("old b3", int'(match), 0);
    applyStimulus(1, 0, 0, 0); checkOutput("old b4", int'(match), 0);
    checkOutput("prog count", int'(match_count), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
